// File: rtl/mpf_vtp_ooo_pkg.sv
`default_nettype none
// ============================================================================
// Module : mpf_vtp_ooo_pkg
// Brief  : Shared types and helpers for the out-of-order VTP translation channel.
// Rev    : 1.0 - initial release
// ============================================================================
package mpf_vtp_ooo_pkg;

    // Per-entry status bits. Payload fields are held in separate arrays so
    // that their widths can follow the module parameters.
    typedef struct packed {
        logic is_sop;
        logic needs_xlate;
        logic issued;
        logic done;
        logic error;
    } t_ooo_entry;

    // Wide enough for any supported ring depth; modules narrow it locally.
    typedef logic [7:0] t_ooo_idx;

    function automatic int ooo_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_plat_prim_burstcount_sop_tracker.sv
`default_nettype none
// ============================================================================
// Module : ofs_plat_prim_burstcount_sop_tracker
// Brief  : Flags start-of-packet flits from the burstcount of accepted flits.
// Rev    : 1.0 - initial release
// ============================================================================
module ofs_plat_prim_burstcount_sop_tracker #(
    parameter int BURST_CNT_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flit_valid,
    input  logic [BURST_CNT_WIDTH-1:0] burstcount,
    output logic                       sop
);

    logic [BURST_CNT_WIDTH-1:0] r_remain;

    assign sop = (r_remain == '0);

    // A zero burstcount is treated as a single-flit burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remain <= '0;
        end else if (flit_valid) begin
            if (sop) begin
                r_remain <= (burstcount > BURST_CNT_WIDTH'(1)) ?
                            burstcount - BURST_CNT_WIDTH'(1) : '0;
            end else begin
                r_remain <= r_remain - BURST_CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mpf_vtp_translate_ooo_chan.sv
`default_nettype none
// ============================================================================
// Module : mpf_vtp_translate_ooo_chan
// Brief  : Ring-buffered VA->PA translation with out-of-order lookups and
//          in-order release of Avalon-style request flits.
// Rev    : 1.0 - initial release
// ============================================================================
module mpf_vtp_translate_ooo_chan
    import mpf_vtp_ooo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 42,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int N_OPAQUE_BITS   = 16,
    parameter int DEPTH           = 16,
    parameter int FAIL_ON_ERROR   = 1,
    parameter int ERR_CNT_WIDTH   = 16,
    localparam int IDX_W          = ooo_clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_waitrequest,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic                       req_is_virtual,
    input  logic [BURST_CNT_WIDTH-1:0] req_burstcount,
    input  logic [N_OPAQUE_BITS-1:0]   req_opaque,
    output logic                       vtp_req_valid,
    input  logic                       vtp_req_ready,
    output logic [ADDR_WIDTH-1:0]      vtp_req_addr,
    output logic [IDX_W-1:0]           vtp_req_tag,
    output logic                       vtp_req_speculative,
    input  logic                       vtp_rsp_valid,
    input  logic [IDX_W-1:0]           vtp_rsp_tag,
    input  logic [ADDR_WIDTH-1:0]      vtp_rsp_addr,
    input  logic                       vtp_rsp_error,
    output logic                       out_valid,
    input  logic                       out_waitrequest,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic [BURST_CNT_WIDTH-1:0] out_burstcount,
    output logic [N_OPAQUE_BITS-1:0]   out_opaque,
    output logic                       error_pulse,
    output logic                       error_stuck,
    output logic [ERR_CNT_WIDTH-1:0]   error_count,
    output logic [IDX_W:0]             in_flight
);

    t_ooo_entry                 r_flags [DEPTH];
    logic [ADDR_WIDTH-1:0]      r_addr  [DEPTH];
    logic [BURST_CNT_WIDTH-1:0] r_bcnt  [DEPTH];
    logic [N_OPAQUE_BITS-1:0]   r_opq   [DEPTH];

    logic [IDX_W-1:0]           r_alloc, r_issue, r_head;
    logic [IDX_W:0]             r_in_flight, r_unissued;
    logic [ADDR_WIDTH-1:0]      r_lat_addr;
    logic                       r_lat_err;
    logic                       r_stuck, r_err_pulse;
    logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;

    logic                       w_sop, w_enq, w_enq_xlate;
    logic                       w_issue_pend, w_issue_adv, w_rsp_hit;
    logic                       w_head_valid, w_head_sop, w_cur_err, w_deq, w_err_evt;
    logic [ADDR_WIDTH-1:0]      w_cur_addr;

    ofs_plat_prim_burstcount_sop_tracker #(
        .BURST_CNT_WIDTH (BURST_CNT_WIDTH)
    ) u_sop (
        .clk        (clk),
        .reset      (reset),
        .flit_valid (w_enq),
        .burstcount (req_burstcount),
        .sop        (w_sop)
    );

    assign req_waitrequest = (r_in_flight == (IDX_W+1)'(DEPTH));
    assign w_enq           = req_valid && !req_waitrequest;
    assign w_enq_xlate     = w_sop && req_is_virtual;

    // Only issued-but-incomplete entries accept a response; stale tags fall through.
    assign w_issue_pend = (r_unissued != '0);
    assign w_issue_adv  = w_issue_pend && (!r_flags[r_issue].needs_xlate || vtp_req_ready);
    assign w_rsp_hit    = vtp_rsp_valid && r_flags[vtp_rsp_tag].issued && !r_flags[vtp_rsp_tag].done;

    assign w_head_valid = (r_in_flight != '0) && r_flags[r_head].done;
    assign w_head_sop   = r_flags[r_head].is_sop;
    assign w_cur_addr   = w_head_sop ? r_addr[r_head] : r_lat_addr;
    assign w_cur_err    = w_head_sop ? r_flags[r_head].error : r_lat_err;
    assign w_deq        = w_head_valid && (w_cur_err ? (FAIL_ON_ERROR == 0) : !out_waitrequest);
    assign w_err_evt    = w_head_valid && w_cur_err && w_head_sop && !r_stuck;

    assign vtp_req_valid       = w_issue_pend && r_flags[r_issue].needs_xlate;
    assign vtp_req_addr        = vtp_req_valid ? r_addr[r_issue] : '0;
    assign vtp_req_tag         = r_issue;
    assign vtp_req_speculative = (FAIL_ON_ERROR == 0);

    assign out_valid      = w_head_valid && !w_cur_err;
    assign out_addr       = w_head_valid ? w_cur_addr : '0;
    assign out_burstcount = w_head_valid ? r_bcnt[r_head] : '0;
    assign out_opaque     = w_head_valid ? r_opq[r_head] : '0;
    assign error_pulse    = r_err_pulse;
    assign error_stuck    = r_stuck;
    assign error_count    = r_err_cnt;
    assign in_flight      = r_in_flight;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_flags[i] <= '0;
            r_alloc     <= '0;
            r_issue     <= '0;
            r_head      <= '0;
            r_in_flight <= '0;
            r_unissued  <= '0;
            r_lat_addr  <= '0;
            r_lat_err   <= 1'b0;
            r_stuck     <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_enq) begin
                r_flags[r_alloc] <= '{is_sop: w_sop, needs_xlate: w_enq_xlate,
                                      issued: 1'b0, done: !w_enq_xlate, error: 1'b0};
                r_alloc <= r_alloc + IDX_W'(1);
            end
            if (w_issue_adv) begin
                if (r_flags[r_issue].needs_xlate) r_flags[r_issue].issued <= 1'b1;
                r_issue <= r_issue + IDX_W'(1);
            end
            if (w_rsp_hit) begin
                r_flags[vtp_rsp_tag].done  <= 1'b1;
                r_flags[vtp_rsp_tag].error <= vtp_rsp_error;
            end
            if (w_head_valid && w_head_sop) begin
                r_lat_addr <= r_addr[r_head];
                r_lat_err  <= r_flags[r_head].error;
            end
            if (w_deq) r_head <= r_head + IDX_W'(1);

            r_in_flight <= r_in_flight + (IDX_W+1)'(w_enq) - (IDX_W+1)'(w_deq);
            r_unissued  <= r_unissued + (IDX_W+1)'(w_enq) - (IDX_W+1)'(w_issue_adv);

            r_err_pulse <= w_err_evt;
            if (w_err_evt && (FAIL_ON_ERROR != 0)) r_stuck <= 1'b1;
            if (w_err_evt && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

    // Payload storage carries no reset; validity is governed by the flags.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_alloc] <= req_addr;
            r_bcnt[r_alloc] <= req_burstcount;
            r_opq[r_alloc]  <= req_opaque;
        end
        if (w_rsp_hit) r_addr[vtp_rsp_tag] <= vtp_rsp_addr;
    end

endmodule
`default_nettype wire

// File: tb/tb_mpf_vtp_translate_ooo_chan.sv
`default_nettype none
// ============================================================================
// Module : tb_mpf_vtp_translate_ooo_chan
// Brief  : Directed bench; instance a blocks on error, instance b drops.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mpf_vtp_translate_ooo_chan;

    logic        clk, reset;
    logic        req_valid, req_is_virtual;
    logic [41:0] req_addr;
    logic [6:0]  req_burstcount;
    logic [15:0] req_opaque;
    logic        vtp_req_ready, vtp_rsp_valid, vtp_rsp_error, out_waitrequest;
    logic [3:0]  vtp_rsp_tag;
    logic [41:0] vtp_rsp_addr;

    logic        req_waitrequest_a, vtp_req_valid_a, vtp_req_spec_a, out_valid_a;
    logic        error_pulse_a, error_stuck_a;
    logic [41:0] vtp_req_addr_a, out_addr_a;
    logic [3:0]  vtp_req_tag_a;
    logic [6:0]  out_burstcount_a;
    logic [15:0] out_opaque_a, error_count_a;
    logic [4:0]  in_flight_a;

    logic        req_waitrequest_b, vtp_req_valid_b, vtp_req_spec_b, out_valid_b;
    logic        error_pulse_b, error_stuck_b;
    logic [41:0] vtp_req_addr_b, out_addr_b;
    logic [3:0]  vtp_req_tag_b;
    logic [6:0]  out_burstcount_b;
    logic [15:0] out_opaque_b, error_count_b;
    logic [4:0]  in_flight_b;

    int checks = 0;
    int failures = 0;
    int lookups_a = 0;
    int pulses_b = 0;

    mpf_vtp_translate_ooo_chan #(.FAIL_ON_ERROR(1)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_waitrequest(req_waitrequest_a), .req_addr(req_addr),
        .req_is_virtual(req_is_virtual), .req_burstcount(req_burstcount), .req_opaque(req_opaque),
        .vtp_req_valid(vtp_req_valid_a), .vtp_req_ready(vtp_req_ready), .vtp_req_addr(vtp_req_addr_a),
        .vtp_req_tag(vtp_req_tag_a), .vtp_req_speculative(vtp_req_spec_a),
        .vtp_rsp_valid(vtp_rsp_valid), .vtp_rsp_tag(vtp_rsp_tag), .vtp_rsp_addr(vtp_rsp_addr),
        .vtp_rsp_error(vtp_rsp_error),
        .out_valid(out_valid_a), .out_waitrequest(out_waitrequest), .out_addr(out_addr_a),
        .out_burstcount(out_burstcount_a), .out_opaque(out_opaque_a),
        .error_pulse(error_pulse_a), .error_stuck(error_stuck_a), .error_count(error_count_a),
        .in_flight(in_flight_a)
    );

    mpf_vtp_translate_ooo_chan #(.FAIL_ON_ERROR(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_waitrequest(req_waitrequest_b), .req_addr(req_addr),
        .req_is_virtual(req_is_virtual), .req_burstcount(req_burstcount), .req_opaque(req_opaque),
        .vtp_req_valid(vtp_req_valid_b), .vtp_req_ready(vtp_req_ready), .vtp_req_addr(vtp_req_addr_b),
        .vtp_req_tag(vtp_req_tag_b), .vtp_req_speculative(vtp_req_spec_b),
        .vtp_rsp_valid(vtp_rsp_valid), .vtp_rsp_tag(vtp_rsp_tag), .vtp_rsp_addr(vtp_rsp_addr),
        .vtp_rsp_error(vtp_rsp_error),
        .out_valid(out_valid_b), .out_waitrequest(out_waitrequest), .out_addr(out_addr_b),
        .out_burstcount(out_burstcount_b), .out_opaque(out_opaque_b),
        .error_pulse(error_pulse_b), .error_stuck(error_stuck_b), .error_count(error_count_b),
        .in_flight(in_flight_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vtp_req_valid_a && vtp_req_ready) lookups_a <= lookups_a + 1;
        if (error_pulse_b) pulses_b <= pulses_b + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [41:0] a, input logic virt, input logic [6:0] bc,
                             input logic [15:0] opq);
        req_valid = 1'b1; req_addr = a; req_is_virtual = virt;
        req_burstcount = bc; req_opaque = opq;
    endtask

    task automatic drive_rsp(input logic [3:0] tag, input logic [41:0] a, input logic err);
        vtp_rsp_valid = 1'b1; vtp_rsp_tag = tag; vtp_rsp_addr = a; vtp_rsp_error = err;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_is_virtual = 1'b0;
        req_burstcount = 7'd1; req_opaque = '0; vtp_req_ready = 1'b1;
        vtp_rsp_valid = 1'b0; vtp_rsp_tag = '0; vtp_rsp_addr = '0; vtp_rsp_error = 1'b0;
        out_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_in_flight", in_flight_a, 0);
        chk("rst_vtp_valid", vtp_req_valid_a, 0);
        chk("rst_err_count", error_count_a, 0);
        chk("rst_out_addr", out_addr_a, 0);
        nxt();
        reset = 1'b0;

        // Single virtual SOP, response three cycles after issue
        drive_req(42'h1000, 1'b1, 7'd1, 16'hA5A5);
        #3 chk("t1_waitreq", req_waitrequest_a, 0);
        nxt(); req_valid = 1'b0;
        #3 chk("t1_vtp_valid", vtp_req_valid_a, 1);
        chk("t1_vtp_addr", vtp_req_addr_a, 42'h1000);
        chk("t1_vtp_tag", vtp_req_tag_a, 0);
        chk("t1_in_flight", in_flight_a, 1);
        nxt();
        #3 chk("t1_vtp_idle", vtp_req_valid_a, 0);
        nxt(); nxt();
        drive_rsp(4'd0, 42'h8000, 1'b0);
        #3 chk("t1_no_out_yet", out_valid_a, 0);
        nxt(); vtp_rsp_valid = 1'b0;
        #3 chk("t1_out_valid", out_valid_a, 1);
        chk("t1_out_addr", out_addr_a, 42'h8000);
        chk("t1_out_opq", out_opaque_a, 16'hA5A5);
        chk("t1_out_bc", out_burstcount_a, 1);
        nxt();
        #3 chk("t1_drained", in_flight_a, 0);
        chk("t1_out_idle", out_valid_a, 0);

        // Burst of 4 sharing one lookup (slots 1..4)
        for (int i = 0; i < 4; i++) begin
            drive_req(42'h2000 + 42'(i), 1'b1, 7'd4, 16'(i + 1));
            nxt();
        end
        req_valid = 1'b0;
        drive_rsp(4'd1, 42'h9000, 1'b0);
        #3 chk("t2_no_out_yet", out_valid_a, 0);
        nxt(); vtp_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3 chk("t2_out_valid", out_valid_a, 1);
            chk("t2_out_addr", out_addr_a, 42'h9000);
            chk("t2_out_opq", out_opaque_a, 16'(i + 1));
            nxt();
        end
        #3 chk("t2_lookups", lookups_a, 2);
        chk("t2_out_idle", out_valid_a, 0);

        // Three lookups (slots 5,6,7) answered 7,5,6
        for (int i = 0; i < 3; i++) begin
            drive_req(42'h3000 + 42'(i * 256), 1'b1, 7'd1, 16'(8'h31 + i));
            nxt();
        end
        req_valid = 1'b0;
        nxt(); nxt();
        drive_rsp(4'd7, 42'hC200, 1'b0);
        #3 chk("t3_hold_a", out_valid_a, 0);
        nxt(); drive_rsp(4'd5, 42'hC000, 1'b0);
        #3 chk("t3_hold_b", out_valid_a, 0);
        nxt(); drive_rsp(4'd6, 42'hC100, 1'b0);
        #3 chk("t3_o0_addr", out_addr_a, 42'hC000);
        chk("t3_o0_opq", out_opaque_a, 16'h31);
        nxt(); vtp_rsp_valid = 1'b0;
        #3 chk("t3_o1_addr", out_addr_a, 42'hC100);
        chk("t3_o1_opq", out_opaque_a, 16'h32);
        nxt();
        #3 chk("t3_o2_addr", out_addr_a, 42'hC200);
        chk("t3_o2_valid", out_valid_a, 1);
        nxt();
        #3 chk("t3_drained", in_flight_a, 0);

        // Fill with 16 physical flits under backpressure, then drain across the wrap
        out_waitrequest = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_req(42'h100 + 42'(i), 1'b0, 7'd1, 16'(i));
            #3 chk("t4_accepting", req_waitrequest_a, 0);
            nxt();
        end
        drive_req(42'h200, 1'b0, 7'd1, 16'h99);
        #3 chk("t4_full_wait", req_waitrequest_a, 1);
        chk("t4_full_count", in_flight_a, 16);
        chk("t4_head_addr", out_addr_a, 42'h100);
        nxt();
        #3 chk("t4_still_full", in_flight_a, 16);
        req_valid = 1'b0;
        out_waitrequest = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #3 chk("t4_drain_valid", out_valid_a, 1);
            chk("t4_drain_addr", out_addr_a, 42'h100 + 42'(i));
            nxt();
        end
        #3 chk("t4_empty", in_flight_a, 0);
        drive_req(42'h777, 1'b0, 7'd1, 16'h77);
        nxt(); req_valid = 1'b0;
        #3 chk("t4_resume_valid", out_valid_a, 1);
        chk("t4_resume_addr", out_addr_a, 42'h777);
        nxt();

        // Errored burst of 3 (slots 9..11) followed by a good flit (slot 12)
        for (int i = 0; i < 3; i++) begin
            drive_req(42'h4000 + 42'(i), 1'b1, 7'd3, 16'(8'h41 + i));
            nxt();
        end
        drive_req(42'h5000, 1'b0, 7'd1, 16'h55);
        nxt(); req_valid = 1'b0;
        drive_rsp(4'd9, 42'h0, 1'b1);
        #3 chk("t5_b_wait", out_valid_b, 0);
        nxt(); vtp_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3 chk("t5_b_dropped", out_valid_b, 0);
            nxt();
        end
        #3 chk("t5_b_good_valid", out_valid_b, 1);
        chk("t5_b_good_addr", out_addr_b, 42'h5000);
        chk("t5_b_good_opq", out_opaque_b, 16'h55);
        nxt();
        #3 chk("t5_b_pulses", pulses_b, 1);
        chk("t5_b_err_count", error_count_b, 1);
        chk("t5_b_not_stuck", error_stuck_b, 0);
        chk("t5_b_empty", in_flight_b, 0);
        chk("t6_a_stuck", error_stuck_a, 1);
        chk("t6_a_blocked", out_valid_a, 0);
        chk("t6_a_in_flight", in_flight_a, 4);
        chk("t6_a_err_count", error_count_a, 1);
        nxt();

        // Reset while blocked, stale response, then normal traffic
        reset = 1'b1;
        #3 chk("t6_rst_stuck", error_stuck_a, 0);
        chk("t6_rst_count", error_count_a, 0);
        chk("t6_rst_in_flight", in_flight_a, 0);
        chk("t6_rst_out_valid", out_valid_a, 0);
        chk("t6_rst_pulse", error_pulse_a, 0);
        chk("t6_rst_wait", req_waitrequest_a, 0);
        nxt();
        reset = 1'b0;
        drive_rsp(4'd9, 42'h123, 1'b0);
        nxt(); vtp_rsp_valid = 1'b0;
        #3 chk("t6_stale_out", out_valid_a, 0);
        chk("t6_stale_in_flight", in_flight_a, 0);
        drive_req(42'h6000, 1'b1, 7'd1, 16'h66);
        nxt(); req_valid = 1'b0;
        #3 chk("t6_vtp_tag", vtp_req_tag_a, 0);
        chk("t6_vtp_addr", vtp_req_addr_a, 42'h6000);
        nxt(); nxt();
        drive_rsp(4'd0, 42'hD000, 1'b0);
        nxt(); vtp_rsp_valid = 1'b0;
        #3 chk("t6_out_valid", out_valid_a, 1);
        chk("t6_out_addr", out_addr_a, 42'hD000);
        chk("t6_out_opq", out_opaque_a, 16'h66);
        chk("t6_not_stuck", error_stuck_a, 0);
        nxt();
        #3 chk("t6_drained", in_flight_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpf_vtp_translate_ooo_chan.md
Name: mpf_vtp_translate_ooo_chan

Overview:
- Parametrised successor to the single-channel ordered VTP translation stage, for Avalon-style memory channels.
- Holds up to DEPTH request flits in a ring buffer.
- Issues tagged VTP lookups for virtual SOP flits; lookups may complete out of order. Releases flits strictly in order.
- Non-SOP flits inherit their burst's translation. Failed bursts are blocked or dropped per FAIL_ON_ERROR, with error counting.
- Instantiated once per read or write channel between AFU-side (VA) and FIU-side (IOVA/PA) interfaces.

Parameters:
- ADDR_WIDTH, 42, line-address width on both sides.
- BURST_CNT_WIDTH, 7, Avalon burstcount width.
- N_OPAQUE_BITS, 16, payload carried untouched (data/byteenable/function).
- DEPTH, 16, ring entries and maximum outstanding lookups; power of 2, at least 2.
- FAIL_ON_ERROR, 1, 1: error blocks the pipeline; 0: errored burst is dropped and reported.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  AFU flit valid.
- req_waitrequest  out  1  high when the ring is full.
- req_addr  in  ADDR_WIDTH  VA, or PA when not virtual.
- req_is_virtual  in  1  translate this SOP address.
- req_burstcount  in  BURST_CNT_WIDTH  burst length, sampled at SOP.
- req_opaque  in  N_OPAQUE_BITS  pass-through payload.
- vtp_req_valid  out  1  lookup request.
- vtp_req_ready  in  1  VTP accepts the lookup.
- vtp_req_addr  out  ADDR_WIDTH  VA to translate.
- vtp_req_tag  out  log2(DEPTH)  ring index.
- vtp_req_speculative  out  1  equals (FAIL_ON_ERROR==0).
- vtp_rsp_valid  in  1  lookup done.
- vtp_rsp_tag  in  log2(DEPTH)  ring index of the completed lookup.
- vtp_rsp_addr  in  ADDR_WIDTH  translated address.
- vtp_rsp_error  in  1  no translation.
- out_valid  out  1  FIU flit valid.
- out_waitrequest  in  1  FIU backpressure.
- out_addr  out  ADDR_WIDTH  translated address.
- out_burstcount  out  BURST_CNT_WIDTH  as enqueued.
- out_opaque  out  N_OPAQUE_BITS  as enqueued.
- error_pulse  out  1  one cycle per errored burst.
- error_stuck  out  1  FAIL_ON_ERROR=1 pipeline blocked.
- error_count  out  ERR_CNT_WIDTH  saturating count of errored bursts.
- in_flight  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- **Reset.** All pointers and counts go to 0; every entry's done flag clears; burst latch clears. All outputs are 0, except req_waitrequest, which is 0 once reset deasserts. A reset mid-operation discards all entries; late vtp_rsp after reset is ignored because no entry awaits it.
- **Ring pointers.** Three pointers: alloc (tail), issue, head. Entry fields: addr, is_sop, needs_xlate, done, error, burstcount, opaque.
- **Enqueue.** req_waitrequest = (in_flight==DEPTH), combinational from registered state. A flit is accepted when req_valid && !req_waitrequest. SOP is tracked by the burstcount SOP tracker.
  - SOP && req_is_virtual: needs_xlate=1, done=0.
  - Otherwise: done=1 at enqueue.
- **Issue.** The issue pointer advances past entries with needs_xlate=0 one per cycle, and never passes alloc. When it points at needs_xlate=1, vtp_req_valid=1 with addr and tag = index; it advances on vtp_req_ready. At most one outstanding lookup per entry.
- **Completion.** On vtp_rsp_valid the entry at tag records addr and error, then sets done. Any completion order is allowed. A response for a non-awaiting tag is ignored.
- **Dequeue.** The head entry is presented when done.
  - Head SOP: out_addr = entry addr; the burst latch captures addr and error.
  - Head non-SOP: out_addr = latched addr; error = latched error.
  - Non-errored: out_valid=1; pop on !out_waitrequest.
  - Errored, FAIL_ON_ERROR=1: out_valid=0, no pop; error_stuck=1 sticky until reset; error_pulse=1 for one cycle on first detection; error_count increments once.
  - Errored, FAIL_ON_ERROR=0: out_valid=0; the flit pops silently one per cycle. error_pulse and error_count increment only at the errored SOP. error_count saturates at all-ones.
- **Simultaneity.** Enqueue, issue, completion and dequeue may all occur in one cycle. in_flight = in_flight + enq − deq. Enqueue into an entry freed the same cycle is disallowed, because waitrequest derives from pre-cycle full.
- **Latency.**
  - Untranslated flit accepted in cycle N: out_valid in N+1.
  - Translated flit: vtp_req_valid no earlier than N+1; out_valid in R+1 after the response in cycle R.
- **Wrap-around.** Pointers are log2(DEPTH) bits and wrap naturally; full vs empty is resolved by in_flight.

Decomposition:
- **Package mpf_vtp_ooo_pkg:** t_ooo_entry struct; t_ooo_idx typedef; function for log2(DEPTH). Parameters are passed as widths.
- **Sub-module:** reuse ofs_plat_prim_burstcount_sop_tracker for SOP detection. Ring storage stays inline.

Test Plan:
- Single virtual SOP, burst 1, VA 0x1000; VTP returns PA 0x8000 three cycles later -> out_addr=0x8000, out_valid at rsp+1, opaque unchanged.
- Burst of 4 flits, VA 0x2000 -> exactly one VTP lookup; all 4 flits emit out_addr=0x9000 in order.
- Lookups for tags 0,1,2 answered in order 2,0,1 -> outputs still in enqueue order 0,1,2.
- Fill with 16 physical flits while out_waitrequest=1 -> req_waitrequest=1, in_flight=16. Release -> 16 flits drain, pointers wrap, accepts resume.
- FAIL_ON_ERROR=0: burst of 3 with vtp_rsp_error=1 followed by a good flit -> no out_valid for the 3, error_pulse once, error_count=1, good flit emitted next.
- FAIL_ON_ERROR=1: errored lookup -> error_stuck=1, out_valid stays 0. Assert reset mid-stream -> all outputs 0, subsequent traffic flows normally.
